// File: rtl/exmem_pkg.sv
// rtl/exmem_pkg.sv - payload type and state encoding shared by the EX->MEM stage
package exmem_pkg;

  localparam int EXMEM_DATA_WIDTH    = 32;
  localparam int EXMEM_RF_ADDR_WIDTH = 5;

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] FULL  = 2'd1;
  localparam logic [1:0] SKID  = 2'd2;

  typedef enum logic [1:0] {
    ST_EMPTY = EMPTY,
    ST_FULL  = FULL,
    ST_SKID  = SKID
  } exmem_state_e;

  typedef struct packed {
    logic [EXMEM_DATA_WIDTH-1:0]    alu_out;
    logic [EXMEM_DATA_WIDTH-1:0]    write_data;
    logic [EXMEM_RF_ADDR_WIDTH-1:0] write_reg;
    logic                           reg_write;
    logic                           memtoreg;
    logic                           mem_write;
  } exmem_payload_t;

endpackage

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - one pipeline slot: valid bit plus payload register
// clear drops only the valid bit; the payload keeps its last value until reset.
module pipe_slot #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign q     = data_q;

endmodule

// File: rtl/execute_to_memory_stage.sv
// rtl/execute_to_memory_stage.sv - EX->MEM register with valid/ready handshake and flush
// EXMEM_SKID_EN adds a second (skid) slot so o_ReadyE comes straight from a flop.
module execute_to_memory_stage
  import exmem_pkg::*;
#(
  parameter int DATA_WIDTH    = EXMEM_DATA_WIDTH,
  parameter int RF_ADDR_WIDTH = EXMEM_RF_ADDR_WIDTH
) (
  input  logic                     i_CLK,
  input  logic                     i_RST,
  input  logic                     i_ValidE,
  output logic                     o_ReadyE,
  input  logic [DATA_WIDTH-1:0]    i_ALUOutE,
  input  logic [DATA_WIDTH-1:0]    i_WriteDataE,
  input  logic [RF_ADDR_WIDTH-1:0] i_WriteRegE,
  input  logic                     i_RegWriteE,
  input  logic                     i_MemtoRegE,
  input  logic                     i_MemWriteE,
  input  logic                     i_FlushM,
  output logic                     o_ValidM,
  input  logic                     i_ReadyM,
  output logic [DATA_WIDTH-1:0]    o_ALUOutM,
  output logic [DATA_WIDTH-1:0]    o_WriteDataM,
  output logic [RF_ADDR_WIDTH-1:0] o_WriteRegM,
  output logic                     o_RegWriteM,
  output logic                     o_MemtoRegM,
  output logic                     o_MemWriteM
);

  localparam int PW = 2*DATA_WIDTH + RF_ADDR_WIDTH + 3;

  exmem_state_e    state, state_d;
  logic            rdy_q, rdy_d;
  logic            accept, release_m;
  logic            m_load, m_clear, m_valid;
  logic [PW-1:0]   in_pay, m_d, m_q;
  logic            reg_write_m, mem_write_m;

  assign in_pay    = {i_ALUOutE, i_WriteDataE, i_WriteRegE, i_RegWriteE, i_MemtoRegE, i_MemWriteE};
  assign accept    = i_ValidE & o_ReadyE;
  assign release_m = m_valid & i_ReadyM;

`ifdef EXMEM_SKID_EN
  logic          s_load, s_clear, s_valid, m_from_s;
  logic [PW-1:0] s_q;

  assign o_ReadyE = rdy_q;
  assign m_d      = m_from_s ? s_q : in_pay;
  // The state is held entirely in the two slot valid bits.
  assign state    = s_valid ? ST_SKID : (m_valid ? ST_FULL : ST_EMPTY);

  pipe_slot #(.W(PW)) u_slot_s (
    .clk(i_CLK), .rst(i_RST), .load(s_load), .clear(s_clear),
    .d(in_pay), .valid(s_valid), .q(s_q)
  );
`else
  assign o_ReadyE = rdy_q & (~m_valid | i_ReadyM);
  assign m_d      = in_pay;
  assign state    = m_valid ? ST_FULL : ST_EMPTY;
`endif

  always_comb begin
    state_d = state;
    m_load  = 1'b0;
    m_clear = 1'b0;
`ifdef EXMEM_SKID_EN
    s_load   = 1'b0;
    s_clear  = 1'b0;
    m_from_s = 1'b0;
`endif
    if (i_FlushM) begin
      // A same-cycle accept completes its handshake but is dropped here.
      state_d = ST_EMPTY;
      m_clear = 1'b1;
`ifdef EXMEM_SKID_EN
      s_clear = 1'b1;
`endif
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            m_load  = 1'b1;
            state_d = ST_FULL;
          end
        end
        ST_FULL: begin
          if (accept) begin
            if (release_m) begin
              m_load = 1'b1;
            end
`ifdef EXMEM_SKID_EN
            else begin
              s_load  = 1'b1;
              state_d = ST_SKID;
            end
`endif
          end else if (release_m) begin
            m_clear = 1'b1;
            state_d = ST_EMPTY;
          end
        end
`ifdef EXMEM_SKID_EN
        ST_SKID: begin
          if (release_m) begin
            m_load   = 1'b1;
            m_from_s = 1'b1;
            s_clear  = 1'b1;
            state_d  = ST_FULL;
          end
        end
`endif
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  assign rdy_d = (state_d != ST_SKID);

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      rdy_q <= 1'b0;
    end else begin
      rdy_q <= rdy_d;
    end
  end

  pipe_slot #(.W(PW)) u_slot_m (
    .clk(i_CLK), .rst(i_RST), .load(m_load), .clear(m_clear),
    .d(m_d), .valid(m_valid), .q(m_q)
  );

  assign {o_ALUOutM, o_WriteDataM, o_WriteRegM, reg_write_m, o_MemtoRegM, mem_write_m} = m_q;
  assign o_ValidM    = m_valid;
  assign o_RegWriteM = m_valid & reg_write_m;
  assign o_MemWriteM = m_valid & mem_write_m;

endmodule

// File: tb/tb_execute_to_memory_stage.sv
// tb/tb_execute_to_memory_stage.sv - scoreboard bench for execute_to_memory_stage
module tb_execute_to_memory_stage;
  import exmem_pkg::*;

`ifdef EXMEM_SKID_EN
  localparam logic SKID_BUILD = 1'b1;
`else
  localparam logic SKID_BUILD = 1'b0;
`endif

  logic        i_CLK = 1'b0;
  logic        i_RST = 1'b0;
  logic        i_ValidE = 1'b0;
  logic        o_ReadyE;
  logic [31:0] i_ALUOutE = '0;
  logic [31:0] i_WriteDataE = '0;
  logic [4:0]  i_WriteRegE = '0;
  logic        i_RegWriteE = 1'b0;
  logic        i_MemtoRegE = 1'b0;
  logic        i_MemWriteE = 1'b0;
  logic        i_FlushM = 1'b0;
  logic        o_ValidM;
  logic        i_ReadyM = 1'b0;
  logic [31:0] o_ALUOutM;
  logic [31:0] o_WriteDataM;
  logic [4:0]  o_WriteRegM;
  logic        o_RegWriteM;
  logic        o_MemtoRegM;
  logic        o_MemWriteM;

  int n_chk = 0;
  int n_fail = 0;
  int n_rel = 0;
  exmem_payload_t sb[$];

  execute_to_memory_stage dut (
    .i_CLK(i_CLK), .i_RST(i_RST), .i_ValidE(i_ValidE), .o_ReadyE(o_ReadyE),
    .i_ALUOutE(i_ALUOutE), .i_WriteDataE(i_WriteDataE), .i_WriteRegE(i_WriteRegE),
    .i_RegWriteE(i_RegWriteE), .i_MemtoRegE(i_MemtoRegE), .i_MemWriteE(i_MemWriteE),
    .i_FlushM(i_FlushM), .o_ValidM(o_ValidM), .i_ReadyM(i_ReadyM),
    .o_ALUOutM(o_ALUOutM), .o_WriteDataM(o_WriteDataM), .o_WriteRegM(o_WriteRegM),
    .o_RegWriteM(o_RegWriteM), .o_MemtoRegM(o_MemtoRegM), .o_MemWriteM(o_MemWriteM)
  );

  always #5 i_CLK = ~i_CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; checks run 1 ns later.
  task automatic cyc(input logic v, input logic [31:0] alu, input logic [31:0] wd,
                     input logic [4:0] wr, input logic rw, input logic m2r, input logic mw,
                     input logic rdy, input logic fl);
    @(negedge i_CLK);
    i_ValidE     = v;
    i_ALUOutE    = alu;
    i_WriteDataE = wd;
    i_WriteRegE  = wr;
    i_RegWriteE  = rw;
    i_MemtoRegE  = m2r;
    i_MemWriteE  = mw;
    i_ReadyM     = rdy;
    i_FlushM     = fl;
    #1;
  endtask

  function automatic logic [63:0] all_outs();
    return {20'd0, o_ReadyE, o_ValidM, o_ALUOutM[15:0], o_WriteDataM[15:0],
            o_WriteRegM, o_RegWriteM, o_MemtoRegM, o_MemWriteM};
  endfunction

  // Monitor: model the stage as a FIFO of accepted entries, compare on every release.
  always begin
    exmem_payload_t exp_p, act_p, in_p;
    @(negedge i_CLK);
    #4;
    if (i_RST) begin
      sb.delete();
    end else begin
      if (o_ValidM && i_ReadyM) begin
        n_rel++;
        n_chk++;
        act_p = '{alu_out: o_ALUOutM, write_data: o_WriteDataM, write_reg: o_WriteRegM,
                  reg_write: o_RegWriteM, memtoreg: o_MemtoRegM, mem_write: o_MemWriteM};
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL release_unexpected: got alu 0x%0h, expected no valid entry", o_ALUOutM);
        end else begin
          exp_p = sb.pop_front();
          if (act_p !== exp_p) begin
            n_fail++;
            $display("FAIL release_payload: got 0x%0h, expected 0x%0h", act_p, exp_p);
          end
        end
      end
      if (i_FlushM) begin
        sb.delete();
      end else if (i_ValidE && o_ReadyE) begin
        in_p = '{alu_out: i_ALUOutE, write_data: i_WriteDataE, write_reg: i_WriteRegE,
                 reg_write: i_RegWriteE, memtoreg: i_MemtoRegE, mem_write: i_MemWriteE};
        sb.push_back(in_p);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    int idx;

    #1 i_RST = 1'b1;
    #1 chk("reset_outs", all_outs(), 64'd0);
    @(negedge i_CLK);
    @(negedge i_CLK);
    i_RST = 1'b0;
    #1 chk("ready_before_first_edge", {63'd0, o_ReadyE}, 64'd0);

    // First accept and its one-cycle latency.
    cyc(1, 32'h0000_00A5, 32'h0, 5'd9, 1, 0, 0, 1, 0);
    chk("ready_after_first_edge", {63'd0, o_ReadyE}, 64'd1);
    cyc(0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 1, 0);
    chk("first_valid", {o_ValidM, o_RegWriteM, o_WriteRegM, o_ALUOutM},
        {1'b1, 1'b1, 5'd9, 32'h0000_00A5});
    cyc(0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 1, 0);
    chk("drained_stale", {o_ValidM, o_RegWriteM, o_MemWriteM, o_ALUOutM},
        {1'b0, 1'b0, 1'b0, 32'h0000_00A5});

    // Full-rate stream.
    base = n_rel;
    for (int k = 1; k <= 8; k++) begin
      cyc(1, 32'(k), 32'(k + 100), 5'(k), 1, 0, 0, 1, 0);
      chk("stream_ready", {63'd0, o_ReadyE}, 64'd1);
    end
    cyc(0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 1, 0);
    cyc(0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 1, 0);
    chk("stream_count", 64'(n_rel - base), 64'd8);

    // Back-pressure: i_ReadyM low for three cycles after entry 1 is presented.
    base = n_rel;
    idx = 1;
    for (int c = 0; c < 16; c++) begin
      cyc(idx <= 4, 32'(idx), 32'(idx + 32'h200), 5'(idx + 10), 1, 0, 0, !(c >= 1 && c <= 3), 0);
      if (c == 1) chk("bp_ready_c1", {63'd0, o_ReadyE}, {63'd0, SKID_BUILD});
      if (c == 2) begin
        chk("bp_ready_c2", {63'd0, o_ReadyE}, 64'd0);
        chk("bp_hold_m", {o_ValidM, o_ALUOutM}, {1'b1, 32'd1});
      end
      if (i_ValidE && o_ReadyE) idx++;
    end
    chk("bp_all_sent", 64'(idx), 64'd5);
    chk("bp_count", 64'(n_rel - base), 64'd4);

    // Flush while back-pressured with store entries held.
    cyc(1, 32'h50, 32'h5050, 5'd4, 0, 0, 1, 1, 0);
    cyc(1, 32'h51, 32'h5151, 5'd5, 0, 0, 1, 0, 0);
    chk("flush_pre", {o_ValidM, o_MemWriteM, o_ALUOutM}, {1'b1, 1'b1, 32'h50});
    cyc(0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 1);
    chk("flush_pre_ready", {63'd0, o_ReadyE}, 64'd0);
    cyc(0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 0);
    chk("flush_post", {o_ValidM, o_MemWriteM, o_ReadyE}, {1'b0, 1'b0, 1'b1});

    // Flush and release together: current entry consumed, new accept dropped.
    cyc(1, 32'h60, 32'h6060, 5'd6, 1, 0, 0, 1, 0);
    base = n_rel;
    cyc(1, 32'h61, 32'h6161, 5'd7, 1, 0, 0, 1, 1);
    cyc(0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 1, 0);
    chk("flush_rel", {o_ValidM, o_RegWriteM, o_ALUOutM}, {1'b0, 1'b0, 32'h60});
    chk("flush_rel_count", 64'(n_rel - base), 64'd1);

    // Invalid entry: write enables gated, memtoreg and payload left as they were.
    cyc(1, 32'h70, 32'h1234, 5'd3, 1, 1, 1, 1, 0);
    cyc(0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 1, 0);
    cyc(0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 1, 0);
    chk("idle_gating", {o_ValidM, o_RegWriteM, o_MemWriteM, o_MemtoRegM},
        {1'b0, 1'b0, 1'b0, 1'b1});
    chk("idle_stale", {o_ALUOutM, o_WriteDataM}, {32'h70, 32'h1234});

    // Asynchronous reset with entries held.
    cyc(1, 32'h80, 32'h8080, 5'd8, 1, 0, 1, 0, 0);
    cyc(1, 32'h81, 32'h8181, 5'd9, 1, 0, 1, 0, 0);
    chk("pre_reset_valid", {63'd0, o_ValidM}, 64'd1);
    #1 i_RST = 1'b1;
    #1 chk("reset_async", all_outs(), 64'd0);
    cyc(0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 1, 0);
    @(negedge i_CLK);
    i_RST = 1'b0;
    #1 chk("reset_release_ready", {63'd0, o_ReadyE}, 64'd0);
    cyc(0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 1, 0);
    chk("reset_first_edge", {o_ReadyE, o_ValidM}, {1'b1, 1'b0});

    cyc(0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 1, 0);
    #4;
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
